// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one slave AXI read port among NUM_MST masters
//   aclk/srst            clock, synchronous active-high reset
//   mst_ar*              per-master AR channels (packed), round-robin arbitrated
//   slv_ar*              single forwarded AR channel, ID tagged {master index, master ID}
//   slv_r* / mst_r*      R channel routed back by the ID tag, payload broadcast
//   ostd_cnt             accepted-but-incomplete bursts, capped at SLV_OSTDREQ_NUM
//   err_bad_rid          one-cycle pulse for each drained beat with an out-of-range tag
module axi_rd_arbiter #(
  parameter int NUM_MST = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W = 4,
  parameter int AXI_DATA_W = 32,
  parameter int SLV_OSTDREQ_NUM = 4,
  localparam int MST_IDX_W = $clog2(NUM_MST),
  localparam int CNT_W = $clog2(SLV_OSTDREQ_NUM + 1)
) (
  input  logic                          aclk,
  input  logic                          srst,
  input  logic [NUM_MST-1:0]            mst_arvalid,
  output logic [NUM_MST-1:0]            mst_arready,
  input  logic [NUM_MST*AXI_ADDR_W-1:0] mst_araddr,
  input  logic [NUM_MST*4-1:0]          mst_arlen,
  input  logic [NUM_MST*AXI_ID_W-1:0]   mst_arid,
  output logic                          slv_arvalid,
  input  logic                          slv_arready,
  output logic [AXI_ADDR_W-1:0]         slv_araddr,
  output logic [3:0]                    slv_arlen,
  output logic [MST_IDX_W+AXI_ID_W-1:0] slv_arid,
  input  logic                          slv_rvalid,
  output logic                          slv_rready,
  input  logic [MST_IDX_W+AXI_ID_W-1:0] slv_rid,
  input  logic [AXI_DATA_W-1:0]         slv_rdata,
  input  logic [1:0]                    slv_rresp,
  input  logic                          slv_rlast,
  output logic [NUM_MST-1:0]            mst_rvalid,
  input  logic [NUM_MST-1:0]            mst_rready,
  output logic [AXI_ID_W-1:0]           mst_rid,
  output logic [AXI_DATA_W-1:0]         mst_rdata,
  output logic [1:0]                    mst_rresp,
  output logic                          mst_rlast,
  output logic [CNT_W-1:0]              ostd_cnt,
  output logic                          err_bad_rid
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(SLV_OSTDREQ_NUM);
  localparam logic [MST_IDX_W-1:0] LAST_MST = MST_IDX_W'(NUM_MST - 1);
  logic [0:0] state;
  logic [MST_IDX_W-1:0] rr_ptr, gnt, r_idx;
  logic ar_cap, r_done, r_ok;
  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    gnt = '0;
    for (int k = NUM_MST - 1; k >= 0; k--)
      if (mst_arvalid[(int'(rr_ptr) + k) % NUM_MST]) gnt = MST_IDX_W'((int'(rr_ptr) + k) % NUM_MST);
  end
  assign ar_cap = (state == IDLE) && (|mst_arvalid) && (ostd_cnt < OSTD_MAX);
  assign mst_arready = ar_cap ? (NUM_MST'(1) << gnt) : '0;
  assign slv_arvalid = (state == GRANT);
  assign r_idx = slv_rid[MST_IDX_W+AXI_ID_W-1:AXI_ID_W];
  assign r_ok = {1'b0, r_idx} < (MST_IDX_W + 1)'(NUM_MST);
  assign mst_rvalid = r_ok ? (NUM_MST'(slv_rvalid) << r_idx) : '0;
  // Beats with an unroutable tag are drained so the slave never stalls on them.
  assign slv_rready = r_ok ? mst_rready[r_idx] : 1'b1;
  assign r_done = slv_rvalid && slv_rready && slv_rlast;
  assign mst_rid = slv_rid[AXI_ID_W-1:0];
  assign mst_rdata = slv_rdata;
  assign mst_rresp = slv_rresp;
  assign mst_rlast = slv_rlast;
  always_ff @(posedge aclk) begin
    if (srst) begin
      state <= IDLE;
      rr_ptr <= '0;
      ostd_cnt <= '0;
      err_bad_rid <= 1'b0;
      slv_araddr <= '0;
      slv_arlen <= '0;
      slv_arid <= '0;
    end else begin
      state <= (state == IDLE) ? (ar_cap ? GRANT : IDLE) : (slv_arready ? IDLE : GRANT);
      err_bad_rid <= slv_rvalid && !r_ok;
      if (ar_cap) begin
        slv_araddr <= mst_araddr[gnt*AXI_ADDR_W +: AXI_ADDR_W];
        slv_arlen <= mst_arlen[gnt*4 +: 4];
        slv_arid <= {gnt, mst_arid[gnt*AXI_ID_W +: AXI_ID_W]};
        rr_ptr <= (gnt == LAST_MST) ? '0 : gnt + 1'b1;
      end
      // A completion with nothing outstanding is a slave protocol error; hold at 0.
      if (ar_cap && !r_done) ostd_cnt <= ostd_cnt + 1'b1;
      else if (!ar_cap && r_done && ostd_cnt != '0) ostd_cnt <= ostd_cnt - 1'b1;
    end
  end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one slave-side AXI read port among NUM_MST masters inside the crossbar; sits between the master AR/R ports and a single slave such as the responder model.
- Arbitrates AR requests round-robin, tags each forwarded ID with the master index, and routes R beats back by that tag.
- Caps total outstanding reads at SLV_OSTDREQ_NUM.

Parameters:
- NUM_MST, 4, number of requesting masters (2..8).
- AXI_ADDR_W, 32, address width.
- AXI_ID_W, 4, master-side ID width.
- AXI_DATA_W, 32, data width.
- SLV_OSTDREQ_NUM, 4, maximum accepted-but-incomplete read bursts (1..15).
- MST_IDX_W, $clog2(NUM_MST), width of the master tag (derived, not overridable).

Ports:
- aclk  in  1  clock
- srst  in  1  synchronous reset, active-high
- mst_arvalid  in  NUM_MST  per-master AR valid
- mst_arready  out  NUM_MST  per-master AR ready
- mst_araddr  in  NUM_MST*AXI_ADDR_W  packed, master i at [i*AXI_ADDR_W +: AXI_ADDR_W]
- mst_arlen  in  NUM_MST*4  packed burst length
- mst_arid  in  NUM_MST*AXI_ID_W  packed ID
- slv_arvalid  out  1  slave AR valid
- slv_arready  in  1  slave AR ready
- slv_araddr  out  AXI_ADDR_W  forwarded address
- slv_arlen  out  4  forwarded length
- slv_arid  out  MST_IDX_W+AXI_ID_W  {master index, master ID}
- slv_rvalid  in  1  slave R valid
- slv_rready  out  1  slave R ready
- slv_rid  in  MST_IDX_W+AXI_ID_W  tagged R ID
- slv_rdata  in  AXI_DATA_W  R data
- slv_rresp  in  2  R response
- slv_rlast  in  1  R last
- mst_rvalid  out  NUM_MST  per-master R valid
- mst_rready  in  NUM_MST  per-master R ready
- mst_rid  out  AXI_ID_W  slv_rid low bits (broadcast)
- mst_rdata  out  AXI_DATA_W  broadcast
- mst_rresp  out  2  broadcast
- mst_rlast  out  1  broadcast
- ostd_cnt  out  $clog2(SLV_OSTDREQ_NUM+1)  current outstanding bursts
- err_bad_rid  out  1  one-cycle pulse on a dropped R beat

Behaviour:
- Reset, while srst=1 at a rising aclk edge:
  - state=IDLE, slv_arvalid=0, ostd_cnt=0, rr_ptr=0 (master 0 has top priority), err_bad_rid=0.
  - AR payload registers cleared to 0.
  - A reset mid-burst abandons all tracking; no R beat is routed as outstanding after reset.
- FSM, two states:
  - IDLE: if any mst_arvalid and ostd_cnt<SLV_OSTDREQ_NUM:
    - Winner g = first set bit of mst_arvalid searching upward from rr_ptr, wrapping.
    - mst_arready[g]=1 combinationally in this cycle; all other mst_arready=0.
    - Capture araddr/arlen and the tag {g, arid} into registers.
    - rr_ptr <= (g+1) mod NUM_MST; ostd_cnt increments; next state GRANT.
    - If ostd_cnt==SLV_OSTDREQ_NUM, all mst_arready=0 and the state stays IDLE.
  - GRANT: slv_arvalid=1 with the registered payload held stable.
    - On slv_arready=1, go to IDLE next cycle with slv_arvalid=0.
    - mst_arready=0 throughout GRANT.
- Latency and throughput:
  - Capture to slv_arvalid is 1 cycle.
  - Peak AR throughput is one burst per 2 cycles.
- ostd_cnt arithmetic:
  - +1 on IDLE capture.
  - -1 on slv_rvalid && slv_rready && slv_rlast.
  - Both in the same cycle: unchanged.
  - Never exceeds SLV_OSTDREQ_NUM. A decrement at 0 is a protocol error and holds at 0.
- R routing is purely combinational:
  - idx = slv_rid[MST_IDX_W+AXI_ID_W-1 : AXI_ID_W].
  - If idx<NUM_MST: mst_rvalid[idx]=slv_rvalid, other bits 0, and slv_rready=mst_rready[idx].
  - If idx>=NUM_MST (only possible for non-power-of-2 NUM_MST): mst_rvalid all 0, slv_rready=1 (the beat is drained), and err_bad_rid=1 registered the next cycle for each such beat.
  - A drained beat with slv_rlast=1 still decrements ostd_cnt.
- Payload: mst_rid, mst_rdata, mst_rresp and mst_rlast pass through unmodified to all masters.
- No reordering: R interleaving across masters is whatever the slave produces; the block does not buffer R.

Test Plan:
- Reset check: hold srst 3 cycles with all inputs 1 -> slv_arvalid=0, ostd_cnt=0, mst_arready=0 in the first cycle after srst falls unless IDLE arbitration applies.
- Round-robin: all 4 mst_arvalid held high, slv_arready=1, R never returned, SLV_OSTDREQ_NUM=4 -> grants in order 0,1,2,3; slv_arid upper bits 0,1,2,3; then ostd_cnt=4 and no fifth grant.
- Backpressure: master 2 only, araddr=0x1000, arlen=3, arid=5; slv_arready low 4 cycles -> slv_arvalid and payload held stable; slv_arid=0x25 on handshake.
- Outstanding release: with ostd_cnt=4, slave returns 4 beats with slv_rid=0x15, rlast on the 4th -> mst_rvalid=4'b0010 on each beat, mst_rid=5, ostd_cnt 4->3 after the last beat, then the next AR grant proceeds.
- Simultaneous events: an AR capture and an R last handshake in the same cycle with ostd_cnt=2 -> ostd_cnt stays 2.
- R backpressure and bad tag: mst_rready[1]=0 while beats are tagged for master 1 -> slv_rready=0. With NUM_MST=3 and slv_rid upper bits=3 -> slv_rready=1, mst_rvalid=0, err_bad_rid pulses 1 cycle later.
